// File: rtl/arith_share_pkg.sv
// Shared types and default sizing for the arithmetic-sharing controller.
// Imported by the controller top and anything that needs its state names.
package arith_share_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after
// lastGnt_i, wrapping modulo NREQ, and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  lastGnt_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW-1:0] cand;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDW'((int'(lastGnt_i) + off) % NREQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arith_share_ctrl.sv
// Round-robin controller sharing one add / shift-add multiply datapath among
// NREQ requesters; results come back tagged with the served requester's ID.
module arith_share_ctrl
    import arith_share_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] a_flat_i,
    input  logic [NREQ*WIDTH-1:0] b_flat_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IDW-1:0]        done_id_o,
    output logic [WIDTH:0]        sum_o,
    output logic [2*WIDTH-1:0]    product_o
);

    localparam int SW = $clog2(WIDTH + 1);

    state_e               state_q,   state_d;
    logic [NREQ-1:0]      gnt_q,     gnt_d;
    logic [IDW-1:0]       id_q,      id_d;
    logic [IDW-1:0]       lastGnt_q, lastGnt_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [SW-1:0]        step_q,    step_d;
    logic [WIDTH:0]       opSum_q,   opSum_d;
    logic [WIDTH:0]       sum_q,     sum_d;
    logic [2*WIDTH-1:0]   prod_q,    prod_d;

    logic [NREQ-1:0]      arbGnt;
    logic [IDW-1:0]       arbIdx;
    logic                 arbValid;
    logic [WIDTH-1:0]     aSel;
    logic [WIDTH-1:0]     bSel;
    logic [2*WIDTH-1:0]   addend;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) uArbiter (
        .req_i     (req_i),
        .lastGnt_i (lastGnt_q),
        .gnt_o     (arbGnt),
        .idx_o     (arbIdx),
        .valid_o   (arbValid)
    );

    assign aSel   = a_flat_i[arbIdx*WIDTH +: WIDTH];
    assign bSel   = b_flat_i[arbIdx*WIDTH +: WIDTH];
    assign addend = mplier_q[0] ? mcand_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            lastGnt_q <= IDW'(NREQ - 1);
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            opSum_q   <= '0;
            sum_q     <= '0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            lastGnt_q <= lastGnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            opSum_q   <= opSum_d;
            sum_q     <= sum_d;
            prod_q    <= prod_d;
        end
    end

    // The sum is formed at acceptance but only published at DONE, so both
    // visible results change together and hold between completions.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        lastGnt_d = lastGnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        step_d    = step_q;
        opSum_d   = opSum_q;
        sum_d     = sum_q;
        prod_d    = prod_q;
        unique case (state_q)
            IDLE: begin
                if (arbValid) begin
                    state_d  = MUL;
                    gnt_d    = arbGnt;
                    id_d     = arbIdx;
                    mcand_d  = {{WIDTH{1'b0}}, aSel};
                    mplier_d = bSel;
                    acc_d    = '0;
                    step_d   = '0;
                    opSum_d  = {1'b0, aSel} + {1'b0, bSel};
                end
            end
            MUL: begin
                acc_d    = acc_q + addend;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                step_d   = step_q + SW'(1);
                if (step_q == SW'(WIDTH - 1)) begin
                    state_d = DONE;
                    prod_d  = acc_q + addend;
                    sum_d   = opSum_q;
                end
            end
            DONE: begin
                state_d   = IDLE;
                gnt_d     = '0;
                lastGnt_d = id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign done_id_o = id_q;
    assign sum_o     = sum_q;
    assign product_o = prod_q;

endmodule
